fifo_wr_arbiter: RTL

Round-robin arbiter sharing the write port of the 3-bit `AsyncFIFO` between several requesters in the write clock domain. Sits directly in front of the FIFO's `wr_*` interface, drives `wr_push`/`wr_data` and never pushes while `wr_full` is high. Grants bounded bursts so one producer cannot monopolise the FIFO. Monitors the FIFO's `wr_ack`/`wr_overflow` feedback and raises sticky error flags.

---
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the AsyncFIFO write port with bounded bursts and sticky error flags.
// Define FIFO_ARB_ACK_CHECK_EN to enable the push/ack consistency check that drives err_ack.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 3,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_push,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_full,
  input  logic                          wr_ack,
  input  logic                          wr_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err_overflow,
  output logic                          err_ack
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, rr_ptr_nx;
  logic [IDW-1:0] owner, owner_nx;
  logic [3:0]     burst_cnt, burst_cnt_nx;
  logic           err_ovf_q;

  logic           sel_valid;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] scan_idx;
  logic           push;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
    return (x == IDW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // In IDLE scan from rr_ptr with wrap; in BURST only the owner may be selected.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    scan_idx  = '0;
    if (state == IDLE) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = IDW'((32'(rr_ptr) + k) % 32'(NUM_REQ));
        if (!sel_valid && req_valid[scan_idx]) begin
          sel_valid = 1'b1;
          sel       = scan_idx;
        end
      end
    end else if (req_valid[owner]) begin
      sel_valid = 1'b1;
      sel       = owner;
    end
  end

  assign push = sel_valid & ~wr_full & ~reset;

  always_comb begin
    req_ready = '0;
    wr_data   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = push && (IDW'(i) == sel);
      if (sel_valid && !reset && (IDW'(i) == sel))
        wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wr_push  = |(req_valid & req_ready);
  assign grant_id = reset ? '0 : ((state == IDLE && push) ? sel : owner);
  assign busy     = (state == BURST) & ~reset;

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    owner_nx     = owner;
    burst_cnt_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (push) begin
          owner_nx     = sel;
          burst_cnt_nx = 4'd1;
          if (MAX_BURST > 1) state_nx  = BURST;
          else               rr_ptr_nx = inc_wrap(sel);
        end
      end
      BURST: begin
        // A stall under wr_full keeps the burst open without counting.
        if (!req_valid[owner]) begin
          state_nx  = IDLE;
          rr_ptr_nx = inc_wrap(owner);
        end else if (push) begin
          burst_cnt_nx = burst_cnt + 4'd1;
          if (burst_cnt_nx == 4'(MAX_BURST)) begin
            state_nx  = IDLE;
            rr_ptr_nx = inc_wrap(owner);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_cnt_nx;
      err_ovf_q <= err_ovf_q | wr_overflow;
    end
  end

  assign err_overflow = err_ovf_q & ~reset;

`ifdef FIFO_ARB_ACK_CHECK_EN
  logic push_d;
  logic err_ack_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      push_d    <= 1'b0;
      err_ack_q <= 1'b0;
    end else begin
      push_d    <= wr_push;
      err_ack_q <= err_ack_q | (push_d ^ wr_ack);
    end
  end

  assign err_ack = err_ack_q & ~reset;
`else
  logic unused_ack;
  assign unused_ack = wr_ack;
  assign err_ack    = 1'b0;
`endif

endmodule
